wb_buffered_stage: RTL
======================

Name: wb_buffered_stage

Overview:
- Parametrised successor to the single-entry write-back stage.
- Holds up to DEPTH completed instructions from the io stage in an in-order FIFO and retires one per cycle to the register file and cp0.
- Forwards buffered results to the id stage per byte lane, and raises exceptions/eret precisely when the faulting entry reaches the head.
- Sits between io stage and register file/cp0; replaces the single-entry stage when retire can be stalled (trace compare, shared regfile port).

Parameters:
- DATA_WIDTH, 32, register/result width; multiple of 8.
- PC_WIDTH, 32, program count width.
- REG_ADDR_WIDTH, 5, register file address width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  io stage presents an entry.
- wb_allow_in  out  1  = !full && !flush_now.
- in_pc  in  PC_WIDTH  program count.
- in_rf_we / in_rf_addr / in_rf_strobe  in  1 / REG_ADDR_WIDTH / DATA_WIDTH/8  register write request.
- in_result  in  DATA_WIDTH  final result.
- in_move_from_cp0 / in_exception_valid / in_eret  in  1 each  entry flags.
- retire_stall  in  1  head must not retire this cycle.
- cp0_read_data  in  DATA_WIDTH  cp0 read value for the head entry.
- rf_we / rf_addr / rf_strobe / rf_data  out  1 / REG_ADDR_WIDTH / DATA_WIDTH/8 / DATA_WIDTH  register file write.
- exception_valid / eret_flush / exception_pc  out  1 / 1 / PC_WIDTH  to cp0 and pipeline flush.
- have_exception_forwards  out  1  any valid buffered entry has an exception or eret.
- query_addr  in  REG_ADDR_WIDTH  id stage lookup address.
- fwd_lane_hit  out  DATA_WIDTH/8  per-lane forward hit.
- fwd_data  out  DATA_WIDTH  forwarded bytes.
- fwd_cp0_pending  out  1  a hit lane's youngest source is an mfc0 entry; id must stall.
- occupancy  out  $clog2(DEPTH+1)  valid entries.
- debug_program_count / debug_rf_we / debug_rf_addr / debug_rf_data  out  PC_WIDTH / DATA_WIDTH/8 / REG_ADDR_WIDTH / DATA_WIDTH  trace.

Behaviour:
- Reset: head, tail and occupancy = 0; all valid bits cleared. All outputs read 0 while empty, except wb_allow_in = 1.
- Enqueue: in_valid && wb_allow_in at the edge writes the tail entry; tail advances mod DEPTH.
  - When full, enqueue is refused even if the head retires in the same cycle.
- Retire: retire_now = !empty && !retire_stall. Head outputs are combinational from the head entry.
  - rf_we = retire_now && head.rf_we && !head.exception.
  - rf_data = head.move_from_cp0 ? cp0_read_data : head.result.
  - debug_rf_we = {N{rf_we}} & head.strobe; debug_program_count = head.pc whenever non-empty.
- Exception/eret: exception_valid = retire_now && head.exception; eret_flush = retire_now && head.eret; exception_pc = head.pc.
  - flush_now = exception_valid || eret_flush.
  - At the flush edge all entries are invalidated, occupancy goes to 0, and any same-cycle enqueue is discarded; wb_allow_in is 0 during flush_now.
- Simultaneous enqueue and retire (non-flush): occupancy unchanged; pointers both advance.
- Latency: an entry enqueued at edge N can retire in cycle N+1; it is forwardable from cycle N+1.
- Forwarding: for each byte lane, scan valid entries youngest to oldest. The first entry with rf_we && !exception && addr == query_addr && strobe[lane] supplies the lane.
  - query_addr == 0 never hits.
  - fwd_cp0_pending = 1 if any hit lane's source entry is move_from_cp0; its fwd_data bytes are then don't-care.
- Reset asserted mid-operation clears the FIFO immediately (asynchronous); no retire or exception pulse is produced.
- Pointer wrap: pointers are $clog2(DEPTH) bits. Full/empty are distinguished by occupancy, not pointer equality.

Decomposition:
- Package wb_buffer_params:
  - wb_entry_t struct: pc, rf_we, rf_addr, strobe, result, move_from_cp0, exception, eret.
  - Lane-count constant DATA_WIDTH/8.
  - Occupancy width function.
- Sub-module wb_forward_lookup: combinational youngest-first per-lane scan over the entry array, using head/tail/valid.

Test Plan:
- Reset, then enqueue pc 0xbfc00000 (rf_we=1, addr=3, strobe=4'hf, result=0x12345678), no stall -> next cycle rf_we=1, rf_addr=3, rf_data=0x12345678, occupancy 1->0.
- retire_stall=1; enqueue 4 entries -> occupancy=4, wb_allow_in=0, 5th in_valid ignored. Release stall -> the 4 entries retire in order on 4 consecutive cycles.
- Buffer two writes to r5 (older strobe 4'hf data 0xAAAAAAAA, younger strobe 4'h1 data 0x000000BB) with retire_stall=1, query 5 -> fwd_lane_hit=4'hf, fwd_data=0xAAAAAABB.
- Head exception at pc 0xbfc00100 with 2 younger entries plus a same-cycle in_valid -> exception_valid=1 and exception_pc=0xbfc00100 for one cycle, rf_we=0, occupancy=0 next cycle, the enqueue is dropped.
- Head mfc0 entry to r8, query 8 while it is held -> fwd_cp0_pending=1. On retire with cp0_read_data=0xDEADBEEF -> rf_data=0xDEADBEEF.
- Fill and drain 3*DEPTH entries with random stalls -> retire order matches enqueue order across pointer wrap; query_addr=0 never hits.

Source files
------------

// File: rtl/wb_buffered_stage_pkg.sv
// Shared widths, entry payload and sizing helper for the buffered write-back stage.
package wb_buffer_params;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned PC_WIDTH       = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned LANES          = DATA_WIDTH / 8;
  localparam int unsigned DEFAULT_DEPTH  = 4;

  typedef struct packed {
    logic [PC_WIDTH-1:0]       pc;
    logic                      rf_we;
    logic [REG_ADDR_WIDTH-1:0] rf_addr;
    logic [LANES-1:0]          strobe;
    logic [DATA_WIDTH-1:0]     result;
    logic                      move_from_cp0;
    logic                      exception;
    logic                      eret;
  } wb_entry_t;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/wb_buffered_stage_if.sv
// io stage -> write-back stage handshake and entry payload.
interface wb_buffered_stage_if;
  import wb_buffer_params::*;

  logic                      in_valid;
  logic                      wb_allow_in;
  logic [PC_WIDTH-1:0]       in_pc;
  logic                      in_rf_we;
  logic [REG_ADDR_WIDTH-1:0] in_rf_addr;
  logic [LANES-1:0]          in_rf_strobe;
  logic [DATA_WIDTH-1:0]     in_result;
  logic                      in_move_from_cp0;
  logic                      in_exception_valid;
  logic                      in_eret;

  modport master (
    output in_valid, in_pc, in_rf_we, in_rf_addr, in_rf_strobe, in_result,
           in_move_from_cp0, in_exception_valid, in_eret,
    input  wb_allow_in
  );

  modport slave (
    input  in_valid, in_pc, in_rf_we, in_rf_addr, in_rf_strobe, in_result,
           in_move_from_cp0, in_exception_valid, in_eret,
    output wb_allow_in
  );
endinterface

// File: rtl/wb_buffered_stage_forward.sv
// Per-byte-lane forwarding: youngest matching buffered write supplies each lane.
module wb_forward_lookup
  import wb_buffer_params::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]          tail,
  input  logic [DEPTH-1:0]          valid,
  input  logic [DEPTH-1:0]          writable,
  input  logic [DEPTH-1:0]          from_cp0,
  input  logic [REG_ADDR_WIDTH-1:0] addr   [DEPTH],
  input  logic [LANES-1:0]          strobe [DEPTH],
  input  logic [DATA_WIDTH-1:0]     result [DEPTH],
  input  logic [REG_ADDR_WIDTH-1:0] query_addr,
  output logic [LANES-1:0]          lane_hit,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      cp0_pending
);
  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    lane_hit    = '0;
    data        = '0;
    cp0_pending = 1'b0;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned lane = 0; lane < LANES; lane++) begin
      found = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx = tail - PTR_W'(k + 1);
        if (!found && query_addr != '0 && valid[idx] && writable[idx] &&
            addr[idx] == query_addr && strobe[idx][lane]) begin
          found                = 1'b1;
          lane_hit[lane]       = 1'b1;
          data[lane*8 +: 8]    = result[idx][lane*8 +: 8];
          if (from_cp0[idx]) cp0_pending = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/wb_buffered_stage.sv
// In-order write-back buffer: queues io-stage results, retires one per cycle, flushes on head exception/eret.
module wb_buffered_stage
  import wb_buffer_params::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  wb_buffered_stage_if.slave        io,
  input  logic                      retire_stall,
  input  logic [DATA_WIDTH-1:0]     cp0_read_data,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr,
  output logic [LANES-1:0]          rf_strobe,
  output logic [DATA_WIDTH-1:0]     rf_data,
  output logic                      exception_valid,
  output logic                      eret_flush,
  output logic [PC_WIDTH-1:0]       exception_pc,
  output logic                      have_exception_forwards,
  input  logic [REG_ADDR_WIDTH-1:0] query_addr,
  output logic [LANES-1:0]          fwd_lane_hit,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic                      fwd_cp0_pending,
  output logic [occ_width(DEPTH)-1:0] occupancy,
  output logic [PC_WIDTH-1:0]       debug_program_count,
  output logic [LANES-1:0]          debug_rf_we,
  output logic [REG_ADDR_WIDTH-1:0] debug_rf_addr,
  output logic [DATA_WIDTH-1:0]     debug_rf_data
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = occ_width(DEPTH);

  wb_entry_t             mem [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      head, tail;
  logic [OCC_W-1:0]      count;
  wb_entry_t             head_e, in_entry;
  logic                  empty, full, retire_now, flush_now, enq;

  assign empty      = (count == '0);
  assign full       = (count == OCC_W'(DEPTH));
  assign head_e     = mem[head];
  assign retire_now = !empty && !retire_stall;

  assign exception_valid = retire_now && head_e.exception;
  assign eret_flush      = retire_now && head_e.eret;
  assign flush_now       = exception_valid || eret_flush;
  assign io.wb_allow_in  = !full && !flush_now;
  assign enq             = io.in_valid && io.wb_allow_in;

  assign in_entry = '{pc: io.in_pc, rf_we: io.in_rf_we, rf_addr: io.in_rf_addr,
                      strobe: io.in_rf_strobe, result: io.in_result,
                      move_from_cp0: io.in_move_from_cp0,
                      exception: io.in_exception_valid, eret: io.in_eret};

  // Head-entry outputs are forced to zero while the buffer is empty.
  assign rf_we        = retire_now && head_e.rf_we && !head_e.exception;
  assign rf_addr      = empty ? '0 : head_e.rf_addr;
  assign rf_strobe    = empty ? '0 : head_e.strobe;
  assign rf_data      = empty ? '0 : (head_e.move_from_cp0 ? cp0_read_data : head_e.result);
  assign exception_pc = empty ? '0 : head_e.pc;

  assign occupancy           = count;
  assign debug_program_count = exception_pc;
  assign debug_rf_we         = {LANES{rf_we}} & head_e.strobe;
  assign debug_rf_addr       = rf_addr;
  assign debug_rf_data       = rf_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else if (flush_now) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (enq) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (retire_now) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (enq && !retire_now)      count <= count + OCC_W'(1);
      else if (!enq && retire_now) count <= count - OCC_W'(1);
    end
  end

  // Payload storage needs no reset: every read is qualified by valid/empty.
  always_ff @(posedge clock) begin
    if (enq) mem[tail] <= in_entry;
  end

  logic [DEPTH-1:0]          e_writable, e_cp0, e_flush;
  logic [REG_ADDR_WIDTH-1:0] e_addr   [DEPTH];
  logic [LANES-1:0]          e_strobe [DEPTH];
  logic [DATA_WIDTH-1:0]     e_result [DEPTH];

  always_comb begin
    e_writable = '0;
    e_cp0      = '0;
    e_flush    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      e_writable[i] = mem[i].rf_we && !mem[i].exception;
      e_cp0[i]      = mem[i].move_from_cp0;
      e_flush[i]    = mem[i].exception || mem[i].eret;
      e_addr[i]     = mem[i].rf_addr;
      e_strobe[i]   = mem[i].strobe;
      e_result[i]   = mem[i].result;
    end
  end

  assign have_exception_forwards = |(valid & e_flush);

  wb_forward_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
    .tail        (tail),
    .valid       (valid),
    .writable    (e_writable),
    .from_cp0    (e_cp0),
    .addr        (e_addr),
    .strobe      (e_strobe),
    .result      (e_result),
    .query_addr  (query_addr),
    .lane_hit    (fwd_lane_hit),
    .data        (fwd_data),
    .cp0_pending (fwd_cp0_pending)
  );
endmodule
